// File: rtl/tx_frame_serializer.sv
// Serial frame transmitter: preamble, SFD, header, 1..MAX_LEN_BYTES payload bytes, CRC-8, MSB first.
// Each line bit is held CLKS_PER_BIT cycles. The block supports abort and payload bit error injection.
module tx_frame_serializer #(
    parameter int         MAX_LEN_BYTES   = 16,
    parameter int         PREAMBLE_BITS   = 16,
    parameter logic [7:0] SFD             = 8'hAB,
    parameter logic [7:0] CRC_POLY        = 8'h07,
    parameter logic [7:0] CRC_INIT        = 8'h00,
    parameter bit         CRC_OVER_HEADER = 1'b0,
    parameter int         CLKS_PER_BIT    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [7:0]                 s_header,
    input  logic [8*MAX_LEN_BYTES-1:0] s_payload,
    input  logic                       inject_en,
    input  logic [7:0]                 inject_bit,
    input  logic                       abort,
    output logic                       tx_line,
    output logic                       tx_busy,
    output logic                       tx_done
);
    localparam int PW   = 8 * MAX_LEN_BYTES;
    localparam int MAXB = (PREAMBLE_BITS > PW) ? PREAMBLE_BITS : PW;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int KW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, PRE, SFD_ST, HDR, DATA, CRC_ST} state_t;

    typedef struct packed {
        logic [7:0]    hdr;
        logic [PW-1:0] pay;     // shifted left as bits go out; top bit is next payload bit
        logic          inj_en;
        logic [7:0]    inj_bit;
        logic [4:0]    nbytes;
    } frame_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, last_data;
    logic [KW-1:0] clk_cnt, clk_nx;
    logic [7:0]    crc, crc_nx;
    frame_t        frm, frm_nx;
    logic          line_nx, busy_nx, done_nx;
    logic          wrap, accept, cov, true_bit;
    logic [4:0]    len_raw;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
        return {c[6:0], 1'b0} ^ ((c[7] ^ d) ? CRC_POLY : 8'h00);
    endfunction

    assign s_ready   = !rst && (state == IDLE) && !abort;
    assign accept    = s_valid && s_ready;
    assign wrap      = (clk_cnt == KW'(CLKS_PER_BIT - 1));
    assign last_data = CW'(8 * int'(frm.nbytes) - 1);
    assign len_raw   = {1'b0, s_header[3:0]} + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            clk_cnt <= '0;
            crc     <= CRC_INIT;
            frm     <= '0;
            tx_line <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            clk_cnt <= clk_nx;
            crc     <= crc_nx;
            frm     <= frm_nx;
            tx_line <= line_nx;
            tx_busy <= busy_nx;
            tx_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clk_nx   = clk_cnt;
        crc_nx   = crc;
        frm_nx   = frm;
        line_nx  = tx_line;
        busy_nx  = tx_busy;
        done_nx  = 1'b0;
        cov      = 1'b0;
        true_bit = 1'b0;

        if (state != IDLE && abort) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            clk_nx   = '0;
            line_nx  = 1'b0;
            busy_nx  = 1'b0;
        end else if (state == IDLE) begin
            line_nx = 1'b0;
            if (accept) begin
                frm_nx.hdr     = s_header;
                frm_nx.pay     = s_payload;
                frm_nx.inj_en  = inject_en;
                frm_nx.inj_bit = inject_bit;
                frm_nx.nbytes  = (len_raw > 5'(MAX_LEN_BYTES)) ? 5'(MAX_LEN_BYTES) : len_raw;
                state_nx = PRE;
                cnt_nx   = '0;
                clk_nx   = '0;
                crc_nx   = CRC_INIT;
                line_nx  = 1'b1;
                busy_nx  = 1'b1;
            end
        end else begin
            clk_nx = wrap ? '0 : clk_cnt + KW'(1);
            if (wrap) begin
                cnt_nx = cnt + CW'(1);
                case (state)
                    PRE:    if (cnt == CW'(PREAMBLE_BITS - 1)) begin state_nx = SFD_ST; cnt_nx = '0; end
                    SFD_ST: if (cnt == CW'(7)) begin state_nx = HDR;  cnt_nx = '0; end
                    HDR:    if (cnt == CW'(7)) begin state_nx = DATA; cnt_nx = '0; end
                    DATA:   if (cnt == last_data) begin state_nx = CRC_ST; cnt_nx = '0; end
                    CRC_ST: if (cnt == CW'(7)) begin state_nx = IDLE; cnt_nx = '0; done_nx = 1'b1; end
                    default: state_nx = IDLE;
                endcase

                // Drive the bit selected by the next position; CRC sees the true bit.
                case (state_nx)
                    PRE:    line_nx = ~cnt_nx[0];
                    SFD_ST: line_nx = SFD[~cnt_nx[2:0]];
                    HDR: begin
                        true_bit = frm.hdr[~cnt_nx[2:0]];
                        cov      = CRC_OVER_HEADER;
                        line_nx  = true_bit;
                    end
                    DATA: begin
                        true_bit   = frm.pay[PW-1];
                        cov        = 1'b1;
                        line_nx    = true_bit ^ (frm.inj_en && (int'(cnt_nx) == int'(frm.inj_bit)));
                        frm_nx.pay = {frm.pay[PW-2:0], 1'b0};
                    end
                    CRC_ST: line_nx = crc[~cnt_nx[2:0]];
                    default: begin
                        line_nx = 1'b0;
                        busy_nx = 1'b0;
                    end
                endcase
                if (cov)
                    crc_nx = crc_step(crc, true_bit);
            end
        end
    end
endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer: default, 4-clocks-per-bit and CRC-over-header instances share stimulus.
module tb_tx_frame_serializer;
    localparam int NC = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [7:0]   s_header = 8'h00;
    logic [127:0] s_payload = '0;
    logic         inject_en = 1'b0;
    logic [7:0]   inject_bit = 8'h00;
    logic         abort = 1'b0;

    logic s_ready_a, tx_line_a, tx_busy_a, tx_done_a;
    logic s_ready_b, tx_line_b, tx_busy_b, tx_done_b;
    logic s_ready_c, tx_line_c, tx_busy_c, tx_done_c;

    logic la [0:NC], ba [0:NC], da [0:NC], ra [0:NC];
    logic lb [0:NC], bb [0:NC], db [0:NC], rb [0:NC];
    logic lc [0:NC], dc [0:NC];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tx_frame_serializer u_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_header(s_header),
        .s_payload(s_payload), .inject_en(inject_en), .inject_bit(inject_bit), .abort(abort),
        .tx_line(tx_line_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a));

    tx_frame_serializer #(.CLKS_PER_BIT(4)) u_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_header(s_header),
        .s_payload(s_payload), .inject_en(inject_en), .inject_bit(inject_bit), .abort(abort),
        .tx_line(tx_line_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b));

    tx_frame_serializer #(.CRC_OVER_HEADER(1'b1)) u_c (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_c), .s_header(s_header),
        .s_payload(s_payload), .inject_en(inject_en), .inject_bit(inject_bit), .abort(abort),
        .tx_line(tx_line_c), .tx_busy(tx_busy_c), .tx_done(tx_done_c));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line bits b0..b0+len-1 of a frame, sampled at the first cycle of each bit period.
    function automatic logic [127:0] seg(input int inst, input int b0, input int len, input int cpb);
        logic [127:0] r = '0;
        for (int i = 0; i < len; i++) begin
            int c = 1 + (b0 + i) * cpb;
            r = {r[126:0], (inst == 0) ? la[c] : (inst == 1) ? lb[c] : lc[c]};
        end
        return r;
    endfunction

    function automatic int first_done(input int inst);
        for (int c = 1; c <= NC; c++)
            if (((inst == 0) ? da[c] : (inst == 1) ? db[c] : dc[c]) === 1'b1) return c;
        return -1;
    endfunction

    function automatic int count_a(input int what);
        int n = 0;
        for (int c = 1; c <= NC; c++)
            if (((what == 0) ? ba[c] : da[c]) === 1'b1) n++;
        return n;
    endfunction

    task automatic start_frame(input logic [7:0] h, input logic [127:0] p, input logic ie, input logic [7:0] ib);
        int w = 0;
        @(negedge clk);
        s_header = h; s_payload = p; inject_en = ie; inject_bit = ib; s_valid = 1'b1;
        while (!s_ready_a && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready_a) chk("accept_timeout", 128'(s_ready_a), 128'(1));
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the frame in flight must not change.
        s_valid = 1'b0; s_header = 8'hFF; s_payload = {4{32'hDEADBEEF}}; inject_en = 1'b1; inject_bit = 8'd1;
    endtask

    task automatic capture(input int abort_at);
        for (int c = 1; c <= NC; c++) begin
            @(negedge clk);
            la[c] = tx_line_a; ba[c] = tx_busy_a; da[c] = tx_done_a; ra[c] = s_ready_a;
            lb[c] = tx_line_b; bb[c] = tx_busy_b; db[c] = tx_done_b; rb[c] = s_ready_b;
            lc[c] = tx_line_c; dc[c] = tx_done_c;
            if (c == abort_at) begin
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
            end
        end
    endtask

    task automatic check_frame_a(input string t, input logic [7:0] h, input logic [127:0] pe,
                                 input int n, input logic [7:0] ce);
        int f = 16 + 24 + 8 * n;
        chk({t, "_pre"},  seg(0, 0, 16, 1), 128'hAAAA);
        chk({t, "_sfd"},  seg(0, 16, 8, 1), 128'hAB);
        chk({t, "_hdr"},  seg(0, 24, 8, 1), 128'(h));
        chk({t, "_pay"},  seg(0, 32, 8 * n, 1), pe);
        chk({t, "_crc"},  seg(0, 32 + 8 * n, 8, 1), 128'(ce));
        chk({t, "_done_at"},  128'(first_done(0)), 128'(f + 1));
        chk({t, "_done_cnt"}, 128'(count_a(1)), 128'(1));
        chk({t, "_busy_cnt"}, 128'(count_a(0)), 128'(f));
        chk({t, "_line_end"}, 128'(la[f + 1]), 128'(0));
        chk({t, "_ready_end"}, 128'(ra[f + 1]), 128'(1));
    endtask

    localparam logic [127:0] PAY1 = {8'h01, {15{8'h5A}}};

    initial begin
        int hold_err;
        int rdy_hi;

        repeat (3) @(negedge clk);
        chk("rst_a", 128'({tx_line_a, tx_busy_a, tx_done_a, s_ready_a}), 128'(0));
        chk("rst_b", 128'({tx_line_b, tx_busy_b, tx_done_b, s_ready_b}), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 128'({s_ready_a, tx_line_a, tx_busy_a}), 128'(3'b100));

        // Basic frame on all three instances.
        start_frame(8'h00, PAY1, 1'b0, 8'd0);
        capture(0);
        check_frame_a("f1", 8'h00, 128'h01, 1, 8'h07);
        chk("f1_busy_first", 128'(ba[1]), 128'(1));
        chk("b_pre", seg(1, 0, 16, 4), 128'hAAAA);
        chk("b_pay", seg(1, 32, 8, 4), 128'h01);
        chk("b_crc", seg(1, 40, 8, 4), 128'h07);
        chk("b_done_at", 128'(first_done(1)), 128'(193));
        hold_err = 0;
        rdy_hi = 0;
        for (int i = 0; i < 48; i++)
            for (int k = 1; k < 4; k++)
                if (lb[1 + 4 * i + k] !== lb[1 + 4 * i]) hold_err++;
        for (int c = 1; c <= 192; c++) if (rb[c] !== 1'b0) rdy_hi++;
        chk("b_hold", 128'(hold_err), 128'(0));
        chk("b_ready_low", 128'(rdy_hi), 128'(0));
        chk("b_ready_end", 128'(rb[193]), 128'(1));
        chk("b_busy_end", 128'(bb[193]), 128'(0));
        chk("c_crc", seg(2, 40, 8, 1), 128'h07);
        chk("c_done_at", 128'(first_done(2)), 128'(49));

        // Full-length frame of zeros.
        start_frame(8'h0F, 128'h0, 1'b0, 8'd0);
        capture(0);
        check_frame_a("f2", 8'h0F, 128'h0, 16, 8'h00);

        // Error injection: in range flips the line bit only, out of range does nothing.
        start_frame(8'h00, PAY1, 1'b1, 8'd7);
        capture(0);
        check_frame_a("inj7", 8'h00, 128'h00, 1, 8'h07);
        start_frame(8'h00, PAY1, 1'b1, 8'd200);
        capture(0);
        check_frame_a("inj200", 8'h00, 128'h01, 1, 8'h07);

        // Abort during the 3rd payload bit (cycle 35).
        start_frame(8'h00, PAY1, 1'b0, 8'd0);
        capture(35);
        chk("abort_busy_before", 128'(ba[35]), 128'(1));
        chk("abort_line", 128'(la[36]), 128'(0));
        chk("abort_busy", 128'(ba[36]), 128'(0));
        chk("abort_ready", 128'(ra[36]), 128'(1));
        chk("abort_no_done", 128'(count_a(1)), 128'(0));
        start_frame(8'h00, PAY1, 1'b0, 8'd0);
        capture(0);
        check_frame_a("post_abort", 8'h00, 128'h01, 1, 8'h07);

        // Reset in the middle of the SFD.
        start_frame(8'h00, PAY1, 1'b0, 8'd0);
        for (int c = 1; c <= 20; c++) @(negedge clk);
        chk("mid_busy", 128'(tx_busy_a), 128'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_a", 128'({tx_line_a, tx_busy_a, tx_done_a, s_ready_a}), 128'(0));
        chk("mid_rst_c", 128'({tx_line_c, tx_busy_c, tx_done_c, s_ready_c}), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 128'({tx_busy_a, tx_done_a}), 128'(0));
        start_frame(8'h00, PAY1, 1'b0, 8'd0);
        capture(0);
        check_frame_a("post_rst", 8'h00, 128'h01, 1, 8'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
